lsu: RTL

//  Load-store unit for the single-cycle RV32I core. Sits downstream of ctrl_unit/ALU:

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_in_sync.sv | 24 ++
 rtl/lsu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the RV32I load-store unit: funct3 access types, the I/O
// address map, the region decode enum and a byte-lane merge helper.
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [31:0] ADDR_LEDR   = 32'h0000_7000;
  localparam logic [31:0] ADDR_LEDG   = 32'h0000_7010;
  localparam logic [31:0] ADDR_HEX_LO = 32'h0000_7020;
  localparam logic [31:0] ADDR_HEX_HI = 32'h0000_7024;
  localparam logic [31:0] ADDR_LCD    = 32'h0000_7030;
  localparam logic [31:0] ADDR_SW     = 32'h0000_7800;
  localparam logic [31:0] ADDR_BTN    = 32'h0000_7810;

  typedef enum logic [3:0] {
    REG_DMEM,
    REG_LEDR,
    REG_LEDG,
    REG_HEX_LO,
    REG_HEX_HI,
    REG_LCD,
    REG_SW,
    REG_BTN,
    REG_NONE
  } region_e;

  // Replace only the byte lanes enabled in be; the rest keep their old value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lsu_in_sync.sv
// Two-flop synchronizer for asynchronous board inputs (switches, buttons).
module lsu_in_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: both flops use non-blocking assignments so q takes the previous meta, giving two stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load-store unit: data memory plus memory-mapped LED/HEX/LCD outputs and synchronized
// switch/button inputs. Define LSU_MISALIGN_CHK_EN to add the misalign output and trap.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_AW = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic        mem_wren,
  input  logic [2:0]  ld_st_type,
  input  logic [31:0] io_sw,
  input  logic [3:0]  io_btn,
  output logic [31:0] ld_data,
  output logic [31:0] io_ledr,
  output logic [31:0] io_ledg,
  output logic [31:0] io_hex_lo,
  output logic [31:0] io_hex_hi,
  output logic [31:0] io_lcd
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [31:0] DMEM_LIMIT = 32'd4 << DMEM_AW;

  logic [31:0] sw_sync;
  logic [3:0]  btn_sync;

  lsu_in_sync #(.W(32)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (io_sw),
    .q   (sw_sync)
  );

  lsu_in_sync #(.W(4)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (io_btn),
    .q   (btn_sync)
  );

  region_e region;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    region = REG_NONE;
    if (addr < DMEM_LIMIT)                      region = REG_DMEM;
    else if (addr[31:2] == ADDR_LEDR[31:2])     region = REG_LEDR;
    else if (addr[31:2] == ADDR_LEDG[31:2])     region = REG_LEDG;
    else if (addr[31:2] == ADDR_HEX_LO[31:2])   region = REG_HEX_LO;
    else if (addr[31:2] == ADDR_HEX_HI[31:2])   region = REG_HEX_HI;
    else if (addr[31:2] == ADDR_LCD[31:2])      region = REG_LCD;
    else if (addr[31:2] == ADDR_SW[31:2])       region = REG_SW;
    else if (addr[31:2] == ADDR_BTN[31:2])      region = REG_BTN;
  end

  logic is_b, is_h, is_w, sext, type_ok, blocked;
  logic [1:0] off;

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    sext = 1'b0;
    case (ld_st_type)
      LS_B:  begin is_b = 1'b1; sext = 1'b1; end
      LS_BU: is_b = 1'b1;
      LS_H:  begin is_h = 1'b1; sext = 1'b1; end
      LS_HU: is_h = 1'b1;
      LS_W:  is_w = 1'b1;
      default: ;
    endcase
  end

  assign type_ok = is_b | is_h | is_w;
  // Halves and words ignore the low address bits they cannot use (forced alignment).
  assign off = is_b ? addr[1:0] : (is_h ? {addr[1], 1'b0} : 2'b00);

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = (is_h & addr[0]) | (is_w & (addr[1:0] != 2'b00));
  assign blocked  = misalign;
`else
  assign blocked  = 1'b0;
`endif

  logic [3:0]  be;
  logic [31:0] wdata;

  // Replicated data lines up with whichever lane the byte enables select.
  always_comb begin
    be    = 4'b0000;
    wdata = st_data;
    if (is_b) begin
      be    = 4'b0001 << off;
      wdata = {4{st_data[7:0]}};
    end else if (is_h) begin
      be    = 4'b0011 << off;
      wdata = {2{st_data[15:0]}};
    end else if (is_w) begin
      be    = 4'b1111;
    end
  end

  logic wr_ok, dmem_we;
  logic [DMEM_AW-1:0] idx;

  assign wr_ok   = mem_wren & type_ok & ~blocked & ~rst;
  assign dmem_we = wr_ok & (region == REG_DMEM);
  assign idx     = addr[DMEM_AW+1:2];

  logic [31:0] dmem [0:(1<<DMEM_AW)-1];

  // NOTE: the memory array has no reset branch; contents survive rst, so the store is gated by ~rst instead.
  always_ff @(posedge clk) begin
    if (dmem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) dmem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_ledr   <= '0;
      io_ledg   <= '0;
      io_hex_lo <= '0;
      io_hex_hi <= '0;
      io_lcd    <= '0;
    end else if (wr_ok) begin
      case (region)
        REG_LEDR:   io_ledr   <= lane_merge(io_ledr,   wdata, be);
        REG_LEDG:   io_ledg   <= lane_merge(io_ledg,   wdata, be);
        REG_HEX_LO: io_hex_lo <= lane_merge(io_hex_lo, wdata, be);
        REG_HEX_HI: io_hex_hi <= lane_merge(io_hex_hi, wdata, be);
        REG_LCD:    io_lcd    <= lane_merge(io_lcd,    wdata, be);
        default: ;
      endcase
    end
  end

  logic [31:0] rd_word, lane;

  always_comb begin
    rd_word = '0;
    case (region)
      REG_DMEM:   rd_word = dmem[idx];
      REG_LEDR:   rd_word = io_ledr;
      REG_LEDG:   rd_word = io_ledg;
      REG_HEX_LO: rd_word = io_hex_lo;
      REG_HEX_HI: rd_word = io_hex_hi;
      REG_LCD:    rd_word = io_lcd;
      REG_SW:     rd_word = sw_sync;
      REG_BTN:    rd_word = {28'd0, btn_sync};
      default: ;
    endcase
  end

  assign lane = rd_word >> {off, 3'b000};

  always_comb begin
    ld_data = '0;
    if (type_ok && !blocked) begin
      if (is_b)      ld_data = sext ? {{24{lane[7]}}, lane[7:0]}   : {24'd0, lane[7:0]};
      else if (is_h) ld_data = sext ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
      else           ld_data = lane;
    end
  end

endmodule
